ring_sequencer: RTL and testbench
=================================

Name: ring_sequencer

Overview:
Parametrised ring sequencer: a chain of N registers, each W bits wide, rotating a stored pattern one stage per step and presenting the last stage on `data`.
- Successor to the fixed 4x4-bit two-register/four-register sequencers.
- Adds:
  - configurable width, depth and initial pattern;
  - forward/backward rotation;
  - runtime pattern reload;
  - manual single-step;
  - a clock-enable tick (no derived clock) from an internal prescaler.
- Drives LEDs or pattern outputs on the board top level.

Parameters:
W, 4, stage width in bits (>=1)
N, 4, number of stages (>=2)
NP, 23, prescaler width; automatic advance every 2^NP clk cycles
INIT, 16'h0569, N*W-bit initial pattern; stage i reset value = INIT[i*W +: W] (default: s0=1001, s1=0110, s2=0101, s3=0000)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset; restores INIT, clears prescaler and idx
en  input  1  1 = prescaler runs and automatic advance allowed; 0 = prescaler frozen
dir  input  1  0 = forward rotation, 1 = backward rotation; sampled on the advance cycle
step  input  1  single-cycle pulse: manual advance, honoured regardless of en
load  input  1  synchronous pattern load request
load_data  input  N*W  new pattern, same packing as INIT
data  output  W  current value of stage N-1
idx  output  max(1,clog2(N))  rotation position modulo N
tick  output  1  registered one-cycle pulse marking each advance (automatic or manual)

Behaviour:
- Reset (rst=0, async):
  - stage[i]=INIT slice;
  - prescaler count=0;
  - idx=0, tick=0;
  - data=INIT[(N-1)*W +: W] (default 4'b0000).
  - Takes effect immediately, mid-operation included.
  - First automatic tick occurs 2^NP enabled cycles after release.
- Prescaler:
  - NP-bit up-counter; increments when en=1, holds when en=0.
  - ptick=1 when en=1 and count is all ones; count wraps to 0 on that cycle.
- Advance condition: adv = ptick | step. Simultaneous ptick and step -> exactly one advance.
- Forward advance (dir=0): stage[i] <= stage[i-1] for i>0; stage[0] <= stage[N-1]; idx <= idx+1, wrapping N-1 -> 0.
- Backward advance (dir=1): stage[i] <= stage[i+1] for i<N-1; stage[N-1] <= stage[0]; idx <= idx-1, wrapping 0 -> N-1.
- Load:
  - On load=1: stage[i] <= load_data slice, idx <= 0.
  - Load has priority over a same-cycle advance; that advance is discarded and tick stays 0.
  - The prescaler keeps counting during load.
- tick: registered; asserted in the cycle after an accepted advance, coincident with the updated `data`.
- Latency: data changes on the clock edge following the adv cycle. No combinational path from inputs to outputs.
- idx is a pure function of rotation history since the last reset/load. After N forward advances, data and idx equal their starting values.
- dir may change on any cycle; there is no pipeline hazard.
- N not a power of two: idx wrap is explicit compare-to-N-1, not natural overflow.

Decomposition:
- Shared package seq_pkg:
  - constants DIR_FWD=1'b0, DIR_BWD=1'b1;
  - function idx_width(N) returning max(1,clog2(N)).
- Sub-module seq_tick_gen (parameter NP; ports clk, rst, en, ptick) holds the prescaler counter. It replaces the derived-clock prescaler so the whole block runs on clk.
- Stage array and idx logic stay in ring_sequencer.

Test Plan:
1. NP=2, defaults, rst low then high, en=1, dir=0 -> data sequence 0000,0101,0110,1001,0000 changing every 4 cycles; idx 0,1,2,3,0; tick one cycle each change.
2. en=0, dir=1, single step pulses -> data 0000,1001,0110,0101,0000; idx 0,3,2,1,0; no automatic advance while en=0 for 100 cycles.
3. Load load_data=16'hFEDC mid-run, same cycle as ptick -> next data=4'hF, idx=0, tick=0; subsequent forward step gives data=4'hE.
4. step coincident with ptick -> single advance, single tick pulse; direction reversal between consecutive steps returns the previous data value.
5. Assert rst low asynchronously between clock edges mid-sequence -> data=0000, idx=0, tick=0 immediately; next tick 4 enabled cycles after release.
6. N=3, W=8, INIT=24'h332211, 7 forward steps -> data 33,22,11,33,22,11,33,22; idx 0,1,2,0,1,2,0,1 (no wrap to 3).

Source files
------------

// File: rtl/seq_pkg.sv
// ============================================================================
//  Module : seq_pkg
//  Shared direction encodings and index-width helper for the ring sequencer.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package seq_pkg;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_BWD = 1'b1;

    // Width of the rotation index; a 1-bit index is kept even when N < 2.
    function automatic int idx_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_tick_gen.sv
// ============================================================================
//  Module : seq_tick_gen
//  Free-running NP-bit prescaler producing a one-cycle clock-enable pulse.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module seq_tick_gen #(
    parameter int NP = 23
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic ptick
);

    logic [NP-1:0] count;

    // Natural overflow gives the wrap to zero on the pulse cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (en) begin
            count <= count + NP'(1);
        end
    end

    assign ptick = en & (&count);

endmodule

`default_nettype wire

// File: rtl/ring_sequencer.sv
// ============================================================================
//  Module : ring_sequencer
//  N-stage, W-bit rotating pattern register with prescaled or manual advance.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module ring_sequencer
    import seq_pkg::*;
#(
    parameter int             W    = 4,
    parameter int             N    = 4,
    parameter int             NP   = 23,
    parameter logic [N*W-1:0] INIT = 16'h0569
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     dir,
    input  logic                     step,
    input  logic                     load,
    input  logic [N*W-1:0]           load_data,
    output logic [W-1:0]             data,
    output logic [idx_width(N)-1:0]  idx,
    output logic                     tick
);

    localparam int            IW       = idx_width(N);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    logic           ptick;
    logic           adv;
    logic [N*W-1:0] ring;
    logic [N*W-1:0] ring_fwd;
    logic [N*W-1:0] ring_bwd;
    logic [IW-1:0]  idx_nxt;

    seq_tick_gen #(
        .NP (NP)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .ptick (ptick)
    );

    assign adv = ptick | step;

    // Both rotated images are precomputed; stage i reads its neighbour.
    generate
        for (genvar i = 0; i < N; i++) begin : g_stage
            localparam int PREV = (i == 0)     ? N - 1 : i - 1;
            localparam int NEXT = (i == N - 1) ? 0     : i + 1;
            assign ring_fwd[i*W +: W] = ring[PREV*W +: W];
            assign ring_bwd[i*W +: W] = ring[NEXT*W +: W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ring <= INIT;
        end else if (load) begin
            ring <= load_data;
        end else if (adv) begin
            ring <= (dir == DIR_BWD) ? ring_bwd : ring_fwd;
        end
    end

    // Explicit wrap compare so non-power-of-two depths never reach N.
    always_comb begin
        idx_nxt = idx;
        if (load) begin
            idx_nxt = '0;
        end else if (adv) begin
            if (dir == DIR_FWD) begin
                idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end else begin
                idx_nxt = (idx == '0) ? IDX_LAST : idx - IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx  <= '0;
            tick <= 1'b0;
        end else begin
            idx  <= idx_nxt;
            tick <= adv & ~load;
        end
    end

    assign data = ring[(N-1)*W +: W];

endmodule

`default_nettype wire

// File: tb/tb_ring_sequencer.sv
// ============================================================================
//  Module : tb_ring_sequencer
//  Self-checking bench for ring_sequencer (default 4x4 and a 3x8 variant).
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ring_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, dir = 1'b0, step = 1'b0, load = 1'b0;
    logic [15:0] load_data = '0;
    logic [3:0]  data;
    logic [1:0]  idx;
    logic        tick;

    logic        step3 = 1'b0;
    logic [7:0]  data3;
    logic [1:0]  idx3;
    logic        tick3;

    always #5 clk = ~clk;

    ring_sequencer #(.W(4), .N(4), .NP(2), .INIT(16'h0569)) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .step(step), .load(load),
        .load_data(load_data), .data(data), .idx(idx), .tick(tick)
    );

    ring_sequencer #(.W(8), .N(3), .NP(4), .INIT(24'h332211)) dut3 (
        .clk(clk), .rst(rst), .en(1'b0), .dir(1'b0), .step(step3), .load(1'b0),
        .load_data(24'h0), .data(data3), .idx(idx3), .tick(tick3)
    );

    typedef struct packed {
        logic        en, dir, step, load;
        logic [15:0] ld;
        logic [3:0]  d;
        logic [1:0]  i;
        logic        t;
    } vec_t;

    typedef struct packed {
        logic [3:0] d;
        logic [1:0] i;
        logic       t;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic void add(input logic e, input logic dr, input logic s, input logic l,
                                input logic [15:0] ld, input logic [3:0] d,
                                input logic [1:0] i, input logic t);
        vec_t v;
        v.en = e; v.dir = dr; v.step = s; v.load = l; v.ld = ld;
        v.d = d; v.i = i; v.t = t;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [3:0] seq_a [5];
        logic [7:0] seq_f [8];
        logic [1:0] idx_f [8];
        exp_t       e;
        vec_t       v;
        string      nm;

        seq_a = '{4'h0, 4'h5, 4'h6, 4'h9, 4'h0};
        seq_f = '{8'h33, 8'h22, 8'h11, 8'h33, 8'h22, 8'h11, 8'h33, 8'h22};
        idx_f = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};

        // Forward auto-advance every 4 cycles after reset release
        for (int k = 1; k <= 16; k++)
            add(1, 0, 0, 0, 16'h0, seq_a[k/4], 2'((k/4) % 4), (k % 4) == 0);
        // Backward manual steps with the prescaler frozen
        add(0, 1, 1, 0, 16'h0, 4'h9, 2'd3, 1);
        add(0, 1, 0, 0, 16'h0, 4'h9, 2'd3, 0);
        add(0, 1, 1, 0, 16'h0, 4'h6, 2'd2, 1);
        add(0, 1, 0, 0, 16'h0, 4'h6, 2'd2, 0);
        add(0, 1, 1, 0, 16'h0, 4'h5, 2'd1, 1);
        add(0, 1, 0, 0, 16'h0, 4'h5, 2'd1, 0);
        add(0, 1, 1, 0, 16'h0, 4'h0, 2'd0, 1);
        for (int k = 0; k < 100; k++)
            add(0, 1, 0, 0, 16'h0, 4'h0, 2'd0, 0);
        // Load on the same cycle as ptick, then a forward step
        for (int k = 0; k < 3; k++)
            add(1, 0, 0, 0, 16'h0, 4'h0, 2'd0, 0);
        add(1, 0, 0, 1, 16'hFEDC, 4'hF, 2'd0, 0);
        add(0, 0, 1, 0, 16'h0, 4'hE, 2'd1, 1);
        add(0, 0, 0, 0, 16'h0, 4'hE, 2'd1, 0);
        // Step coincident with ptick, then a direction reversal
        for (int k = 0; k < 3; k++)
            add(1, 0, 0, 0, 16'h0, 4'hE, 2'd1, 0);
        add(1, 0, 1, 0, 16'h0, 4'hD, 2'd2, 1);
        add(0, 0, 0, 0, 16'h0, 4'hD, 2'd2, 0);
        add(0, 1, 1, 0, 16'h0, 4'hE, 2'd1, 1);
        add(0, 0, 1, 0, 16'h0, 4'hD, 2'd2, 1);
        add(0, 0, 0, 0, 16'h0, 4'hD, 2'd2, 0);

        // Reset state
        #1 rst = 1'b0;
        #7;
        check("reset_data", 32'(data), 32'h0);
        check("reset_idx", 32'(idx), 32'h0);
        check("reset_tick", 32'(tick), 32'h0);
        #4 rst = 1'b1;

        foreach (vecs[n]) begin
            v = vecs[n];
            en = v.en; dir = v.dir; step = v.step; load = v.load; load_data = v.ld;
            sb.push_back('{d: v.d, i: v.i, t: v.t});
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_empty: got 0 entries, required 1");
            end else begin
                e = sb.pop_front();
                nm = $sformatf("vec%0d", n);
                check({nm, "_data"}, 32'(data), 32'(e.d));
                check({nm, "_idx"}, 32'(idx), 32'(e.i));
                check({nm, "_tick"}, 32'(tick), 32'(e.t));
            end
        end

        // Async reset mid-sequence with the prescaler part-way through
        en = 1'b1; dir = 1'b0; step = 1'b0; load = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("pre_rst%0d_tick", k), 32'(tick), 32'(k == 4));
        end
        check("pre_rst_data", 32'(data), 32'hC);
        check("pre_rst_idx", 32'(idx), 32'h3);
        #3 rst = 1'b0;
        #1;
        check("async_rst_data", 32'(data), 32'h0);
        check("async_rst_idx", 32'(idx), 32'h0);
        check("async_rst_tick", 32'(tick), 32'h0);
        #2 rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst%0d_tick", k), 32'(tick), 32'(k == 4));
        end
        check("post_rst_data", 32'(data), 32'h5);
        check("post_rst_idx", 32'(idx), 32'h1);
        en = 1'b0;

        // Non-power-of-two depth: N=3, W=8
        check("n3_init_data", 32'(data3), 32'(seq_f[0]));
        check("n3_init_idx", 32'(idx3), 32'(idx_f[0]));
        for (int k = 1; k <= 7; k++) begin
            step3 = 1'b1;
            @(posedge clk);
            #1;
            step3 = 1'b0;
            check($sformatf("n3_step%0d_data", k), 32'(data3), 32'(seq_f[k]));
            check($sformatf("n3_step%0d_idx", k), 32'(idx3), 32'(idx_f[k]));
            check($sformatf("n3_step%0d_tick", k), 32'(tick3), 32'h1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
